// File: rtl/enum_stepper_if.sv
// Command port of enum_stepper: op/step channel with valid/ready handshake.
// With ENUM_STEPPER_LOAD_EN defined the raw-value load channel is carried here as well.
interface enum_stepper_if #(
`ifdef ENUM_STEPPER_LOAD_EN
    parameter int DW    = 32,
`endif
    parameter int STEPW = 8
);
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [1:0]       cmd_op;
    logic [STEPW-1:0] cmd_n;
`ifdef ENUM_STEPPER_LOAD_EN
    logic             ld_vld;
    logic [DW-1:0]    ld_val;
    logic             ld_hit;
`endif

    modport master (
        output cmd_vld,
        output cmd_op,
        output cmd_n,
`ifdef ENUM_STEPPER_LOAD_EN
        output ld_vld,
        output ld_val,
        input  ld_hit,
`endif
        input  cmd_rdy
    );

    modport slave (
        input  cmd_vld,
        input  cmd_op,
        input  cmd_n,
`ifdef ENUM_STEPPER_LOAD_EN
        input  ld_vld,
        input  ld_val,
        output ld_hit,
`endif
        output cmd_rdy
    );
endinterface

// File: rtl/enum_stepper.sv
// Register walking a sparse enumeration table like SV enum first/last/next(N)/prev(N).
// Optional raw-value search/load is enabled by defining ENUM_STEPPER_LOAD_EN.
module enum_stepper #(
    parameter int                DW     = 32,
    parameter int                NUM    = 8,
    parameter logic [NUM*DW-1:0] VALUES = {32'd7, 32'd6, 32'd5, 32'd4,
                                           32'd3, 32'd2, 32'd1, 32'd0},
    parameter int                STEPW  = 8,
    parameter int                WCW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    enum_stepper_if.slave            cmd,
    output logic [DW-1:0]            cur_val,
    output logic [$clog2(NUM)-1:0]   cur_idx,
    output logic                     done,
    output logic [WCW-1:0]           wrap_cnt
);
    localparam int           IW       = $clog2(NUM);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM - 1);

    typedef enum logic [1:0] {
        OP_FIRST = 2'd0,
        OP_LAST  = 2'd1,
        OP_NEXT  = 2'd2,
        OP_PREV  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef ENUM_STEPPER_LOAD_EN
        S_SEARCH = 2'd2,
`endif
        S_STEP   = 2'd1
    } state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [DW-1:0]    val_reg;
    logic [STEPW-1:0] rem_reg, rem_next;
    logic             dir_reg, dir_next;
    logic [WCW-1:0]   wrap_reg, wrap_next;
    logic             done_reg, done_next;
`ifdef ENUM_STEPPER_LOAD_EN
    logic [IW-1:0]    srch_reg, srch_next;
    logic [DW-1:0]    key_reg, key_next;
    logic             hit_reg, hit_next;
`endif

    // Unpacked view of the packed value table
    logic [DW-1:0] entry_w [NUM];
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_entry
            assign entry_w[gi] = VALUES[gi*DW +: DW];
        end
    endgenerate

    // One step in the latched direction, flagging an index wrap
    logic [IW-1:0] step_idx;
    logic          step_wrap;
    always_comb begin
        step_idx  = idx_reg;
        step_wrap = 1'b0;
        if (dir_reg) begin
            if (idx_reg == '0) begin
                step_idx  = LAST_IDX;
                step_wrap = 1'b1;
            end else begin
                step_idx = idx_reg - IW'(1);
            end
        end else begin
            if (idx_reg == LAST_IDX) begin
                step_idx  = '0;
                step_wrap = 1'b1;
            end else begin
                step_idx = idx_reg + IW'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        rem_next   = rem_reg;
        dir_next   = dir_reg;
        wrap_next  = wrap_reg;
        done_next  = 1'b0;
`ifdef ENUM_STEPPER_LOAD_EN
        srch_next  = srch_reg;
        key_next   = key_reg;
        hit_next   = hit_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (cmd.cmd_vld) begin
                    case (op_t'(cmd.cmd_op))
                        OP_FIRST: begin
                            idx_next  = '0;
                            done_next = 1'b1;
                        end
                        OP_LAST: begin
                            idx_next  = LAST_IDX;
                            done_next = 1'b1;
                        end
                        default: begin
                            // A zero step count behaves as a single step
                            dir_next   = (op_t'(cmd.cmd_op) == OP_PREV);
                            rem_next   = (cmd.cmd_n == '0) ? STEPW'(1) : cmd.cmd_n;
                            state_next = S_STEP;
                        end
                    endcase
                end
`ifdef ENUM_STEPPER_LOAD_EN
                else if (cmd.ld_vld) begin
                    key_next   = cmd.ld_val;
                    srch_next  = '0;
                    state_next = S_SEARCH;
                end
`endif
            end
            S_STEP: begin
                idx_next = step_idx;
                rem_next = rem_reg - STEPW'(1);
                if (step_wrap) begin
                    wrap_next = wrap_reg + WCW'(1);
                end
                if (rem_reg == STEPW'(1)) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
`ifdef ENUM_STEPPER_LOAD_EN
            S_SEARCH: begin
                if (entry_w[srch_reg] == key_reg) begin
                    idx_next   = srch_reg;
                    hit_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (srch_reg == LAST_IDX) begin
                    hit_next   = 1'b0;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    srch_next = srch_reg + IW'(1);
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // cur_val is looked up from the next index so both change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            val_reg  <= VALUES[DW-1:0];
            rem_reg  <= '0;
            dir_reg  <= 1'b0;
            wrap_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            val_reg  <= entry_w[idx_next];
            rem_reg  <= rem_next;
            dir_reg  <= dir_next;
            wrap_reg <= wrap_next;
            done_reg <= done_next;
        end
    end

`ifdef ENUM_STEPPER_LOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srch_reg <= '0;
            key_reg  <= '0;
            hit_reg  <= 1'b0;
        end else begin
            srch_reg <= srch_next;
            key_reg  <= key_next;
            hit_reg  <= hit_next;
        end
    end

    assign cmd.ld_hit = hit_reg;
`endif

    assign cmd.cmd_rdy = (state_reg == S_IDLE);
    assign cur_idx     = idx_reg;
    assign cur_val     = val_reg;
    assign done        = done_reg;
    assign wrap_cnt    = wrap_reg;
endmodule

// File: tb/tb_enum_stepper.sv
// Self-checking bench for enum_stepper: vector table with scoreboard plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_enum_stepper;
    localparam int DW    = 8;
    localparam int NUM   = 4;
    localparam int STEPW = 4;
    localparam int WCW   = 4;
    localparam int IW    = 2;
    localparam logic [NUM*DW-1:0] VALUES = {8'd20, 8'd10, 8'd1, 8'd0};

    localparam logic [1:0] FIRST = 2'd0;
    localparam logic [1:0] LAST  = 2'd1;
    localparam logic [1:0] NEXT  = 2'd2;
    localparam logic [1:0] PREV  = 2'd3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  cur_val;
    logic [IW-1:0]  cur_idx;
    logic           done;
    logic [WCW-1:0] wrap_cnt;

`ifdef ENUM_STEPPER_LOAD_EN
    enum_stepper_if #(.DW(DW), .STEPW(STEPW)) cmd ();
`else
    enum_stepper_if #(.STEPW(STEPW)) cmd ();
`endif

    enum_stepper #(
        .DW(DW), .NUM(NUM), .VALUES(VALUES), .STEPW(STEPW), .WCW(WCW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .cur_val(cur_val),
        .cur_idx(cur_idx),
        .done(done),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] n;
        int         idx;
        int         val;
        int         wrap;
        int         lat;
    } vec_t;

    typedef struct {
        int idx;
        int val;
        int wrap;
        int lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one command, then count cycles after the accept edge until done
    task automatic issue(input logic [1:0] op, input logic [3:0] n, output int lat);
        @(negedge clk);
        cmd.cmd_vld = 1'b1;
        cmd.cmd_op  = op;
        cmd.cmd_n   = n;
        @(posedge clk);
        @(negedge clk);
        cmd.cmd_vld = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within %0d cycles", lat);
        end
    endtask

    task automatic run_vec(input int k);
        exp_t e;
        int   lat;
        sb.push_back('{vecs[k].idx, vecs[k].val, vecs[k].wrap, vecs[k].lat});
        issue(vecs[k].op, vecs[k].n, lat);
        e = sb.pop_front();
        $display("txn %0d op=%0d n=%0d idx=%0d val=%0d wrap=%0d lat=%0d",
                 k, vecs[k].op, vecs[k].n, cur_idx, cur_val, wrap_cnt, lat);
        chk($sformatf("vec%0d idx", k), cur_idx, e.idx);
        chk($sformatf("vec%0d val", k), cur_val, e.val);
        chk($sformatf("vec%0d wrap", k), wrap_cnt, e.wrap);
        chk($sformatf("vec%0d lat", k), lat, e.lat);
        chk($sformatf("vec%0d rdy", k), cmd.cmd_rdy, 1);
    endtask

`ifdef ENUM_STEPPER_LOAD_EN
    task automatic do_load(input logic [DW-1:0] v, output int lat);
        @(negedge clk);
        cmd.ld_vld = 1'b1;
        cmd.ld_val = v;
        @(posedge clk);
        @(negedge clk);
        cmd.ld_vld = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load timeout: done not seen within %0d cycles", lat);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic saw_done;

        // Expected results hand-derived from VALUES = {0,1,10,20}, WCW = 4
        vecs[0]  = '{NEXT,  4'd2,  1,  1,  1,  2};
        vecs[1]  = '{PREV,  4'd0,  0,  0,  1,  1};
        vecs[2]  = '{PREV,  4'd1,  3, 20,  2,  1};
        vecs[3]  = '{NEXT,  4'd9,  0,  0,  5,  9};
        vecs[4]  = '{LAST,  4'd0,  3, 20,  5,  0};
        vecs[5]  = '{FIRST, 4'd0,  0,  0,  5,  0};
        vecs[6]  = '{PREV,  4'd6,  2, 10,  7,  6};
        vecs[7]  = '{NEXT,  4'd15, 1,  1, 11, 15};
        vecs[8]  = '{PREV,  4'd15, 2, 10, 15, 15};
        vecs[9]  = '{NEXT,  4'd1,  3, 20, 15,  1};
        vecs[10] = '{NEXT,  4'd1,  0,  0,  0,  1};
        vecs[11] = '{LAST,  4'd0,  3, 20,  0,  0};
        vecs[12] = '{FIRST, 4'd0,  0,  0,  0,  0};

        cmd.cmd_vld = 1'b0;
        cmd.cmd_op  = FIRST;
        cmd.cmd_n   = '0;
`ifdef ENUM_STEPPER_LOAD_EN
        cmd.ld_vld  = 1'b0;
        cmd.ld_val  = '0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst idx", cur_idx, 0);
        chk("rst val", cur_val, 0);
        chk("rst wrap", wrap_cnt, 0);
        chk("rst done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel rdy", cmd.cmd_rdy, 1);
        chk("rel idx", cur_idx, 0);
        chk("rel done", done, 0);
`ifdef ENUM_STEPPER_LOAD_EN
        chk("rel ld_hit", cmd.ld_hit, 0);
`endif

        // NEXT 3: one entry per cycle, busy until the last step
        @(negedge clk);
        cmd.cmd_vld = 1'b1;
        cmd.cmd_op  = NEXT;
        cmd.cmd_n   = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cmd.cmd_vld = 1'b0;
        chk("n3 c0 rdy", cmd.cmd_rdy, 0);
        chk("n3 c0 val", cur_val, 0);
        chk("n3 c0 done", done, 0);
        @(negedge clk);
        chk("n3 c1 rdy", cmd.cmd_rdy, 0);
        chk("n3 c1 val", cur_val, 1);
        @(negedge clk);
        chk("n3 c2 rdy", cmd.cmd_rdy, 0);
        chk("n3 c2 val", cur_val, 10);
        chk("n3 c2 done", done, 0);
        @(negedge clk);
        chk("n3 c3 val", cur_val, 20);
        chk("n3 c3 idx", cur_idx, 3);
        chk("n3 c3 done", done, 1);
        chk("n3 c3 rdy", cmd.cmd_rdy, 1);
        chk("n3 c3 wrap", wrap_cnt, 0);
        $display("txn hand next3 idx=%0d val=%0d wrap=%0d", cur_idx, cur_val, wrap_cnt);

        for (int k = 0; k < 13; k++) begin
            run_vec(k);
        end

        // LAST then FIRST accepted on consecutive edges
        @(negedge clk);
        cmd.cmd_vld = 1'b1;
        cmd.cmd_op  = LAST;
        @(posedge clk);
        @(negedge clk);
        chk("b2b last idx", cur_idx, 3);
        chk("b2b last val", cur_val, 20);
        chk("b2b last done", done, 1);
        cmd.cmd_op = FIRST;
        @(posedge clk);
        @(negedge clk);
        cmd.cmd_vld = 1'b0;
        chk("b2b first idx", cur_idx, 0);
        chk("b2b first val", cur_val, 0);
        chk("b2b first done", done, 1);
        @(negedge clk);
        chk("b2b done pulse", done, 0);
        chk("b2b wrap", wrap_cnt, 0);
        $display("txn hand last/first idx=%0d val=%0d", cur_idx, cur_val);

        // NEXT 8 with a busy-time command pulse, then reset mid-walk
        @(negedge clk);
        cmd.cmd_vld = 1'b1;
        cmd.cmd_op  = NEXT;
        cmd.cmd_n   = 4'd8;
        @(posedge clk);
        @(negedge clk);
        cmd.cmd_vld = 1'b0;
        @(negedge clk);
        chk("abort s1 idx", cur_idx, 1);
        cmd.cmd_vld = 1'b1;
        cmd.cmd_op  = FIRST;
        @(negedge clk);
        cmd.cmd_vld = 1'b0;
        chk("busy ignore idx", cur_idx, 2);
        chk("busy rdy", cmd.cmd_rdy, 0);
        @(negedge clk);
        chk("abort s3 idx", cur_idx, 3);
        @(negedge clk);
        chk("abort s4 wrap", wrap_cnt, 1);
        @(negedge clk);
        chk("abort s5 idx", cur_idx, 1);
        rst_n = 1'b0;
        #1;
        chk("abort idx", cur_idx, 0);
        chk("abort val", cur_val, 0);
        chk("abort wrap", wrap_cnt, 0);
        chk("abort done", done, 0);
        chk("abort rdy", cmd.cmd_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", saw_done, 0);
        chk("abort idle idx", cur_idx, 0);
        $display("txn hand abort idx=%0d wrap=%0d", cur_idx, wrap_cnt);

`ifdef ENUM_STEPPER_LOAD_EN
        do_load(8'd10, lat);
        $display("txn load 10 idx=%0d hit=%0d lat=%0d", cur_idx, cmd.ld_hit, lat);
        chk("ld10 idx", cur_idx, 2);
        chk("ld10 val", cur_val, 10);
        chk("ld10 hit", cmd.ld_hit, 1);
        chk("ld10 lat", lat, 3);
        do_load(8'd5, lat);
        $display("txn load 5 idx=%0d hit=%0d lat=%0d", cur_idx, cmd.ld_hit, lat);
        chk("ld5 idx", cur_idx, 2);
        chk("ld5 hit", cmd.ld_hit, 0);
        chk("ld5 lat", lat, 4);
        @(negedge clk);
        cmd.cmd_vld = 1'b1;
        cmd.cmd_op  = FIRST;
        cmd.ld_vld  = 1'b1;
        cmd.ld_val  = 8'd10;
        @(posedge clk);
        @(negedge clk);
        cmd.cmd_vld = 1'b0;
        cmd.ld_vld  = 1'b0;
        $display("txn cmd+load idx=%0d hit=%0d done=%0d", cur_idx, cmd.ld_hit, done);
        chk("both idx", cur_idx, 0);
        chk("both done", done, 1);
        chk("both hit", cmd.ld_hit, 0);
        @(negedge clk);
        chk("both rdy", cmd.cmd_rdy, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
